cam_px_gen: RTL and testbench

Synthetic camera source that drives the OV7670-style parallel pixel bus (vsync, href, 8-bit data, two bytes per RGB565 pixel) with generated test patterns. It is the transmitter end of the camera capture path. It feeds the capture block in simulation and on hardware when no sensor is fitted, so the frame buffer and VGA path can be brought up with known content. Frame geometry is the frame buffer geometry (160×120) plus configurable blanking.

---
 rtl/cam_pkg.sv | 46 ++++
 rtl/cam_pattern.sv | 49 ++++
 rtl/cam_px_gen.sv | 125 ++++++++++++
 tb/tb_cam_px_gen.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// Shared definitions for the camera source, capture and VGA blocks:
// frame geometry, RGB565 bar colours, FSM states and pattern codes.
package cam_pkg;

    localparam int CAM_H_PX    = 160;
    localparam int CAM_V_LINES = 120;

    localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
    localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
    localparam logic [15:0] RGB_CYAN    = 16'h07FF;
    localparam logic [15:0] RGB_GREEN   = 16'h07E0;
    localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
    localparam logic [15:0] RGB_RED     = 16'hF800;
    localparam logic [15:0] RGB_BLUE    = 16'h001F;
    localparam logic [15:0] RGB_BLACK   = 16'h0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_VBP,
        ST_ACTIVE,
        ST_VFP
    } cam_state_t;

    typedef enum logic [1:0] {
        PAT_BARS,
        PAT_CHECKER,
        PAT_RAMP,
        PAT_SOLID
    } cam_pat_t;

    // Colour bars left to right.
    function automatic logic [15:0] bar_rgb(input logic [2:0] idx);
        case (idx)
            3'd0:    return RGB_WHITE;
            3'd1:    return RGB_YELLOW;
            3'd2:    return RGB_CYAN;
            3'd3:    return RGB_GREEN;
            3'd4:    return RGB_MAGENTA;
            3'd5:    return RGB_RED;
            3'd6:    return RGB_BLUE;
            default: return RGB_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/cam_pattern.sv
// Combinational test-pattern generator: (x, y, pattern, scroll) -> RGB565.
// The scroll input and bar scrolling exist only when CAM_PX_GEN_SCROLL_EN is defined.
module cam_pattern
    import cam_pkg::*;
#(
    parameter  int H_PX    = CAM_H_PX,
    parameter  int V_LINES = CAM_V_LINES,
    localparam int XW      = $clog2(H_PX),
    localparam int YW      = $clog2(V_LINES)
) (
    input  logic [XW-1:0] x,
    input  logic [YW-1:0] y,
    input  logic [1:0]    pat,
`ifdef CAM_PX_GEN_SCROLL_EN
    input  logic [XW-1:0] scroll,
`endif
    output logic [15:0]   rgb
);

    localparam logic [XW-1:0] BAR_W = XW'(H_PX / 8);

    logic [XW-1:0] xs;
    logic [4:0]    ramp_r;

`ifdef CAM_PX_GEN_SCROLL_EN
    localparam logic [XW:0] H_PX_X = (XW+1)'(H_PX);
    logic [XW:0] x_sum;

    // Both operands are below H_PX, so one conditional subtract is the modulo.
    assign x_sum = {1'b0, x} + {1'b0, scroll};
    assign xs    = (x_sum >= H_PX_X) ? XW'(x_sum - H_PX_X) : x_sum[XW-1:0];
`else
    assign xs = x;
`endif

    assign ramp_r = 5'(x >> 3);

    always_comb begin
        // NOTE: rgb gets a default before the case so no latch is inferred.
        rgb = RGB_BLACK;
        case (pat)
            PAT_BARS:    rgb = bar_rgb(3'(xs / BAR_W));
            PAT_CHECKER: rgb = (x[3] ^ y[3]) ? RGB_WHITE : RGB_BLACK;
            PAT_RAMP:    rgb = {ramp_r, 6'(y), ~ramp_r};
            default:     rgb = RGB_GREEN;
        endcase
    end

endmodule

// File: rtl/cam_px_gen.sv
// Synthetic OV7670-style camera source: vsync/href framing and an RGB565 byte stream.
// Define CAM_PX_GEN_SCROLL_EN to scroll the bar pattern one pixel per frame.
module cam_px_gen
    import cam_pkg::*;
#(
    parameter int H_PX      = CAM_H_PX,
    parameter int V_LINES   = CAM_V_LINES,
    parameter int VS_LINES  = 3,
    parameter int VBP_LINES = 2,
    parameter int VFP_LINES = 2,
    parameter int H_BLANK   = 16
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] pattern_sel,
    output logic       vsync,
    output logic       href,
    output logic [7:0] px_data,
    output logic       frame_done
);

    localparam int LINE_CYC = 2 * H_PX + H_BLANK;
    localparam int CW       = $clog2(LINE_CYC);
    localparam int LW       = $clog2(VS_LINES + VBP_LINES + V_LINES + VFP_LINES);
    localparam int XW       = $clog2(H_PX);
    localparam int YW       = $clog2(V_LINES);

    localparam logic [CW-1:0] COL_LAST = CW'(LINE_CYC - 1);
    localparam logic [CW-1:0] HREF_END = CW'(2 * H_PX);
    localparam logic [LW-1:0] VS_LAST  = LW'(VS_LINES - 1);
    localparam logic [LW-1:0] VBP_LAST = LW'(VBP_LINES - 1);
    localparam logic [LW-1:0] ACT_LAST = LW'(V_LINES - 1);
    localparam logic [LW-1:0] VFP_LAST = LW'(VFP_LINES - 1);

    cam_state_t    state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [LW-1:0] line_q, line_d;
    logic [LW-1:0] line_last;
    logic [1:0]    pat_q;
    logic          href_d;
    logic [15:0]   rgb;

    always_comb begin
        state_d   = state_q;
        col_d     = (col_q == COL_LAST) ? '0 : col_q + CW'(1);
        line_d    = line_q;
        line_last = '0;
        case (state_q)
            ST_VSYNC:  line_last = VS_LAST;
            ST_VBP:    line_last = VBP_LAST;
            ST_ACTIVE: line_last = ACT_LAST;
            ST_VFP:    line_last = VFP_LAST;
            default:   line_last = '0;
        endcase

        if (state_q == ST_IDLE) begin
            col_d  = '0;
            line_d = '0;
            if (en) state_d = ST_VSYNC;
        end else if (col_q == COL_LAST) begin
            if (line_q == line_last) begin
                line_d = '0;
                case (state_q)
                    ST_VSYNC:  state_d = ST_VBP;
                    ST_VBP:    state_d = ST_ACTIVE;
                    ST_ACTIVE: state_d = ST_VFP;
                    default:   state_d = en ? ST_VSYNC : ST_IDLE;
                endcase
            end else begin
                line_d = line_q + LW'(1);
            end
        end
    end

    // Outputs are registered from next-state values so they align with the state they describe.
    assign href_d = (state_d == ST_ACTIVE) && (col_d < HREF_END);

`ifdef CAM_PX_GEN_SCROLL_EN
    localparam logic [XW-1:0] X_LAST = XW'(H_PX - 1);
    logic [XW-1:0] scroll_q;

    always_ff @(posedge pclk or posedge rst) begin
        if (rst)             scroll_q <= '0;
        else if (frame_done) scroll_q <= (scroll_q == X_LAST) ? '0 : scroll_q + XW'(1);
    end
`endif

    cam_pattern #(
        .H_PX    (H_PX),
        .V_LINES (V_LINES)
    ) u_pattern (
        .x      (col_d[XW:1]),
        .y      (line_d[YW-1:0]),
        .pat    (pat_q),
`ifdef CAM_PX_GEN_SCROLL_EN
        .scroll (scroll_q),
`endif
        .rgb    (rgb)
    );

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            col_q      <= '0;
            line_q     <= '0;
            pat_q      <= '0;
            vsync      <= 1'b0;
            href       <= 1'b0;
            px_data    <= 8'h00;
            frame_done <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            state_q    <= state_d;
            col_q      <= col_d;
            line_q     <= line_d;
            if (state_q != ST_VSYNC && state_d == ST_VSYNC) pat_q <= pattern_sel;
            vsync      <= (state_d == ST_VSYNC);
            href       <= href_d;
            px_data    <= !href_d ? 8'h00 : (col_d[0] ? rgb[7:0] : rgb[15:8]);
            frame_done <= (state_d == ST_VFP) && (col_d == COL_LAST) && (line_d == VFP_LAST);
        end
    end

endmodule

// File: tb/tb_cam_px_gen.sv
// Directed bench for cam_px_gen at default geometry: framing, solid/bar/checker
// patterns, mid-frame en/pattern changes, asynchronous reset and restart.
module tb_cam_px_gen;

    localparam int LINE_BYTES = 320;

`ifdef CAM_PX_GEN_SCROLL_EN
    localparam logic [15:0] BARS_X19  = 16'hFFE0;
    localparam logic [15:0] BARS_X159 = 16'hFFFF;
`else
    localparam logic [15:0] BARS_X19  = 16'hFFFF;
    localparam logic [15:0] BARS_X159 = 16'h0000;
`endif

    logic       pclk;
    logic       rst;
    logic       en;
    logic [1:0] pattern_sel;
    logic       vsync;
    logic       href;
    logic [7:0] px_data;
    logic       frame_done;

    int total;
    int bad;

    int   cyc, vs_cnt, href_lines, bpos, lo_gap, first_href, fd_cnt, fd_cyc;
    int   w_bad, gap_bad, byte_bad, blank_bad;
    logic prev_href;
    bit   solid_chk;
    logic [7:0] line0 [LINE_BYTES];
    logic [7:0] line8 [LINE_BYTES];

    cam_px_gen dut (
        .pclk        (pclk),
        .rst         (rst),
        .en          (en),
        .pattern_sel (pattern_sel),
        .vsync       (vsync),
        .href        (href),
        .px_data     (px_data),
        .frame_done  (frame_done)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        cyc = 0; vs_cnt = 0; href_lines = 0; bpos = 0; lo_gap = 0;
        first_href = 0; fd_cnt = 0; fd_cyc = 0;
        w_bad = 0; gap_bad = 0; byte_bad = 0; blank_bad = 0;
        prev_href = 1'b0;
    endtask

    // Advance one cycle, sample on the falling edge and accumulate frame statistics.
    task automatic tick();
        @(negedge pclk);
        cyc++;
        if (vsync) vs_cnt++;
        if (frame_done) begin
            fd_cnt++;
            fd_cyc = cyc;
        end
        if (href) begin
            if (!prev_href) begin
                href_lines++;
                if (first_href == 0) first_href = cyc;
                if (href_lines > 1 && lo_gap != 16) gap_bad++;
                bpos = 0;
            end
            if (bpos < LINE_BYTES) begin
                if (href_lines == 1) line0[bpos] = px_data;
                if (href_lines == 9) line8[bpos] = px_data;
            end
            if (solid_chk && px_data !== ((bpos % 2 == 0) ? 8'h07 : 8'hE0)) byte_bad++;
            bpos++;
        end else begin
            if (prev_href) begin
                if (bpos != LINE_BYTES) w_bad++;
                lo_gap = 0;
            end
            lo_gap++;
            if (px_data !== 8'h00) blank_bad++;
        end
        prev_href = href;
    endtask

    function automatic logic [15:0] pair0(input int x);
        return {line0[2*x], line0[2*x+1]};
    endfunction

    function automatic logic [15:0] pair8(input int x);
        return {line8[2*x], line8[2*x+1]};
    endfunction

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1;
        en = 1'b1;
        pattern_sel = 2'd3;
        solid_chk = 1'b0;
        clear_stats();

        repeat (3) @(negedge pclk);
        check("rst_vsync", vsync, 1'b0);
        check("rst_href", href, 1'b0);
        check("rst_px", px_data, 8'h00);
        check("rst_done", frame_done, 1'b0);

        // Solid green frame; en drop and pattern change inside ACTIVE.
        rst = 1'b0;
        clear_stats();
        solid_chk = 1'b1;
        tick();
        check("en_to_vsync", vsync, 1'b1);
        while (fd_cnt == 0 && cyc < 50000) begin
            tick();
            if (href_lines == 61 && en) begin
                en = 1'b0;
                pattern_sel = 2'd0;
            end
        end
        check("f1_vsync_len", vs_cnt, 1008);
        check("f1_first_href", first_href, 1681);
        check("f1_lines", href_lines, 120);
        check("f1_width_bad", w_bad, 0);
        check("f1_gap_bad", gap_bad, 0);
        check("f1_green_bad", byte_bad, 0);
        check("f1_blank_bad", blank_bad, 0);
        check("f1_done_cyc", fd_cyc, 42672);

        repeat (400) tick();
        check("idle_no_vsync", vs_cnt, 1008);
        check("idle_done_once", fd_cnt, 1);
        check("idle_no_href", href_lines, 120);

        // Re-enable: bars latched at this VSYNC entry.
        en = 1'b1;
        clear_stats();
        solid_chk = 1'b0;
        while (href_lines < 2 && cyc < 5000) tick();
        check("bars_vsync_len", vs_cnt, 1008);
        check("bars_x0", pair0(0), 16'hFFFF);
        check("bars_x19", pair0(19), BARS_X19);
        check("bars_x20", pair0(20), 16'hFFE0);
        check("bars_x100", pair0(100), 16'hF800);
        check("bars_x159", pair0(159), BARS_X159);

        // Asynchronous reset in the middle of an active line.
        check("pre_rst_href", href, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("arst_href", href, 1'b0);
        check("arst_px", px_data, 8'h00);
        check("arst_vsync", vsync, 1'b0);

        repeat (2) @(negedge pclk);
        pattern_sel = 2'd1;
        rst = 1'b0;
        clear_stats();
        tick();
        check("restart_vsync", vsync, 1'b1);
        while (href_lines < 10 && cyc < 8000) tick();
        check("chk_vsync_len", vs_cnt, 1008);
        check("chk_first_href", first_href, 1681);
        check("chk_x0_y0", pair0(0), 16'h0000);
        check("chk_x8_y0", pair0(8), 16'hFFFF);
        check("chk_x8_y8", pair8(8), 16'h0000);
        check("chk_x0_y8", pair8(0), 16'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
